// File: rtl/ahb_burst_arbiter_rr.sv
// rtl/ahb_burst_arbiter_rr.sv - AHB burst-aware bus arbiter and master multiplexer
//
// Purpose:
//   Arbitrates NM AHB-style masters onto one shared slave bus. MODE selects
//   fixed priority (index 0 highest) or round-robin. A master that starts a
//   defined-length burst (4/8/16 beats) keeps the grant for the whole burst.
//   A master that starts a locked transfer keeps the grant until it releases
//   hlock. Address/control are muxed by the address-phase owner (hmaster).
//   Write data is muxed by the data-phase owner.
//
// Ports:
//   hclk, hreset        clock, synchronous active-low reset
//   busreq[NM]          per-master bus request
//   hlock[NM]           per-master locked-transfer request
//   haddr/htrans/       per-master address-phase buses, master i in slice i
//   hburst
//   hwdata              per-master write data, master i in slice i
//   hready              slave ready; advances phases, FSM and beat count
//   hgrant[NM]          registered one-hot grant
//   hmaster[MW]         address-phase owner index
//   hmaster_lock        current transfer is locked
//   haddr_out, htrans_out, hburst_out   muxed by hmaster
//   hwdata_out          muxed by the data-phase owner

module ahb_burst_arbiter_rr #(
   parameter int NM      = 9,
   parameter int MW      = 4,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MODE    = 1,
   parameter int DEF_MST = 0
) (
   input  logic             hclk,
   input  logic             hreset,
   input  logic [NM-1:0]    busreq,
   input  logic [NM-1:0]    hlock,
   input  logic [NM*AW-1:0] haddr,
   input  logic [NM*2-1:0]  htrans,
   input  logic [NM*3-1:0]  hburst,
   input  logic [NM*DW-1:0] hwdata,
   input  logic             hready,
   output logic [NM-1:0]    hgrant,
   output logic [MW-1:0]    hmaster,
   output logic             hmaster_lock,
   output logic [AW-1:0]    haddr_out,
   output logic [1:0]       htrans_out,
   output logic [2:0]       hburst_out,
   output logic [DW-1:0]    hwdata_out
);

   typedef enum logic [1:0] {
      ST_ARB   = 2'd0,
      ST_BURST = 2'd1,
      ST_LOCK  = 2'd2
   } state_t;

   localparam logic [1:0] HT_IDLE   = 2'b00;
   localparam logic [1:0] HT_BUSY   = 2'b01;
   localparam logic [1:0] HT_NONSEQ = 2'b10;
   localparam logic [1:0] HT_SEQ    = 2'b11;

   localparam logic [MW-1:0] DEF_IDX = MW'(DEF_MST);
   localparam logic [NM-1:0] ONE_NM  = {{(NM-1){1'b0}}, 1'b1};

   // Registered state
   state_t        state_q,  state_d;
   logic [NM-1:0] hgrant_q, hgrant_d;
   logic [MW-1:0] hmaster_q, hmaster_d;
   logic [MW-1:0] downer_q, downer_d;   // data-phase owner
   logic          lock_q,   lock_d;
   logic [3:0]    count_q,  count_d;    // beats accepted in the current burst
   logic [3:0]    last_q,   last_d;     // burst length minus one

   // Combinational helpers
   logic [MW-1:0] arb_idx;
   logic          arb_found;
   int            cand;
   logic [MW-1:0] grant_idx;
   logic [NM-1:0] owner_oh;
   logic [3:0]    len_m1;
   logic          fixed_burst;
   logic          is_nonseq;
   logic          is_seq;
   logic          is_busy;
   logic          is_idle;
   logic          owner_lock;

   // Muxing: address phase by hmaster, data phase by the data owner
   always_comb begin
      haddr_out  = haddr[int'(hmaster_q)*AW +: AW];
      htrans_out = htrans[int'(hmaster_q)*2 +: 2];
      hburst_out = hburst[int'(hmaster_q)*3 +: 3];
      hwdata_out = hwdata[int'(downer_q)*DW +: DW];
   end

   // Arbitration winner. Round-robin searches from hmaster+1 and wraps so
   // the current owner is considered last.
   always_comb begin
      arb_idx   = DEF_IDX;
      arb_found = 1'b0;
      cand      = 0;
      if (MODE == 0) begin
         for (int i = NM-1; i >= 0; i--) begin
            if (busreq[i]) arb_idx = MW'(i);
         end
      end else begin
         for (int off = 1; off <= NM; off++) begin
            cand = int'(hmaster_q) + off;
            if (cand >= NM) cand = cand - NM;
            if (!arb_found && busreq[cand]) begin
               arb_idx   = MW'(cand);
               arb_found = 1'b1;
            end
         end
      end
   end

   // Index of the currently granted master
   always_comb begin
      grant_idx = DEF_IDX;
      for (int i = 0; i < NM; i++) begin
         if (hgrant_q[i]) grant_idx = MW'(i);
      end
   end

   always_comb begin
      owner_oh    = ONE_NM << hmaster_q;
      owner_lock  = hlock[hmaster_q];
      is_nonseq   = (htrans_out == HT_NONSEQ);
      is_seq      = (htrans_out == HT_SEQ);
      is_busy     = (htrans_out == HT_BUSY);
      is_idle     = (htrans_out == HT_IDLE);
      // SINGLE (000) and INCR (001) are not fixed-length
      fixed_burst = hburst_out[2] | hburst_out[1];
      case (hburst_out)
         3'b010, 3'b011: len_m1 = 4'd3;
         3'b100, 3'b101: len_m1 = 4'd7;
         3'b110, 3'b111: len_m1 = 4'd15;
         default:        len_m1 = 4'd0;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      hgrant_d  = hgrant_q;
      hmaster_d = hmaster_q;
      downer_d  = downer_q;
      lock_d    = lock_q;
      count_d   = count_q;
      last_d    = last_q;

      case (state_q)
         ST_ARB: begin
            hgrant_d = ONE_NM << arb_idx;
            if (hready) begin
               hmaster_d = grant_idx;
               downer_d  = hmaster_q;
               if (is_nonseq && owner_lock) begin
                  // Owner keeps the bus; grant pinned to it on entry
                  state_d   = ST_LOCK;
                  lock_d    = 1'b1;
                  hgrant_d  = owner_oh;
                  hmaster_d = hmaster_q;
               end else if (is_nonseq && fixed_burst) begin
                  state_d   = ST_BURST;
                  count_d   = 4'd1;
                  last_d    = len_m1;
                  hgrant_d  = owner_oh;
                  hmaster_d = hmaster_q;
               end
            end
         end

         ST_BURST: begin
            if (hready) begin
               downer_d = hmaster_q;
               if (is_seq) begin
                  if (count_q == last_q) begin
                     state_d = ST_ARB;
                     count_d = 4'd0;
                  end else begin
                     count_d = count_q + 4'd1;
                  end
               end else if (is_idle || is_nonseq) begin
                  // Terminated burst
                  state_d = ST_ARB;
                  count_d = 4'd0;
               end
            end
         end

         ST_LOCK: begin
            if (hready) begin
               downer_d = hmaster_q;
               if (!owner_lock && !is_seq && !is_busy) begin
                  state_d = ST_ARB;
                  lock_d  = 1'b0;
               end
            end
         end

         default: begin
            state_d = ST_ARB;
            lock_d  = 1'b0;
            count_d = 4'd0;
         end
      endcase
   end

   always_ff @(posedge hclk) begin
      if (!hreset) begin
         state_q   <= ST_ARB;
         hgrant_q  <= ONE_NM << DEF_IDX;
         hmaster_q <= DEF_IDX;
         downer_q  <= DEF_IDX;
         lock_q    <= 1'b0;
         count_q   <= 4'd0;
         last_q    <= 4'd0;
      end else begin
         state_q   <= state_d;
         hgrant_q  <= hgrant_d;
         hmaster_q <= hmaster_d;
         downer_q  <= downer_d;
         lock_q    <= lock_d;
         count_q   <= count_d;
         last_q    <= last_d;
      end
   end

   assign hgrant       = hgrant_q;
   assign hmaster      = hmaster_q;
   assign hmaster_lock = lock_q;

endmodule

// File: tb/tb_ahb_burst_arbiter_rr.sv
// tb/tb_ahb_burst_arbiter_rr.sv - directed self-checking bench for ahb_burst_arbiter_rr

module tb_ahb_burst_arbiter_rr;

   localparam int NM = 9;
   localparam int MW = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   localparam logic [2:0] B_SINGLE = 3'b000;
   localparam logic [2:0] B_INCR4  = 3'b011;
   localparam logic [2:0] B_INCR8  = 3'b101;
   localparam logic [2:0] B_WRAP16 = 3'b110;

   logic             hclk;
   logic             hreset;
   logic [NM-1:0]    busreq;
   logic [NM-1:0]    hlock;
   logic [NM*AW-1:0] haddr;
   logic [NM*2-1:0]  htrans;
   logic [NM*3-1:0]  hburst;
   logic [NM*DW-1:0] hwdata;
   logic             hready;

   logic [NM-1:0] hgrant_fp, hgrant_rr;
   logic [MW-1:0] hmaster_fp, hmaster_rr;
   logic          hlock_fp, hlock_rr;
   logic [AW-1:0] haddr_fp, haddr_rr;
   logic [1:0]    htrans_fp, htrans_rr;
   logic [2:0]    hburst_fp, hburst_rr;
   logic [DW-1:0] hwdata_fp, hwdata_rr;

   int tests_run;
   int tests_failed;

   ahb_burst_arbiter_rr #(
      .NM(NM), .MW(MW), .AW(AW), .DW(DW), .MODE(0), .DEF_MST(0)
   ) dut_fp (
      .hclk(hclk), .hreset(hreset), .busreq(busreq), .hlock(hlock),
      .haddr(haddr), .htrans(htrans), .hburst(hburst), .hwdata(hwdata),
      .hready(hready), .hgrant(hgrant_fp), .hmaster(hmaster_fp),
      .hmaster_lock(hlock_fp), .haddr_out(haddr_fp), .htrans_out(htrans_fp),
      .hburst_out(hburst_fp), .hwdata_out(hwdata_fp)
   );

   ahb_burst_arbiter_rr #(
      .NM(NM), .MW(MW), .AW(AW), .DW(DW), .MODE(1), .DEF_MST(0)
   ) dut_rr (
      .hclk(hclk), .hreset(hreset), .busreq(busreq), .hlock(hlock),
      .haddr(haddr), .htrans(htrans), .hburst(hburst), .hwdata(hwdata),
      .hready(hready), .hgrant(hgrant_rr), .hmaster(hmaster_rr),
      .hmaster_lock(hlock_rr), .haddr_out(haddr_rr), .htrans_out(htrans_rr),
      .hburst_out(hburst_rr), .hwdata_out(hwdata_rr)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic drive_only(input int m, input logic [1:0] tr, input logic [2:0] bu);
      htrans = '0;
      hburst = '0;
      htrans[m*2 +: 2] = tr;
      hburst[m*3 +: 3] = bu;
   endtask

   task automatic do_reset();
      hreset = 1'b0;
      busreq = '0;
      hlock  = '0;
      htrans = '0;
      hburst = '0;
      hready = 1'b1;
      step();
      step();
      hreset = 1'b1;
   endtask

   task automatic test_reset();
      hreset = 1'b0;
      busreq = 9'h1FF;
      hlock  = '0;
      htrans = '0;
      hburst = '0;
      hready = 1'b1;
      step();
      step();
      tests_run++;
      if (hgrant_rr !== 9'h001) begin
         tests_failed++;
         $display("FAIL reset_hgrant_rr: got %h expected %h", hgrant_rr, 9'h001);
      end
      tests_run++;
      if (hgrant_fp !== 9'h001) begin
         tests_failed++;
         $display("FAIL reset_hgrant_fp: got %h expected %h", hgrant_fp, 9'h001);
      end
      tests_run++;
      if (hmaster_rr !== 4'd0 || hlock_rr !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_master_lock: got %0d/%b expected 0/0", hmaster_rr, hlock_rr);
      end
      tests_run++;
      if (haddr_rr !== 32'hA000_0000 || hwdata_rr !== 32'hD000_0000) begin
         tests_failed++;
         $display("FAIL reset_mux: got %h/%h expected a0000000/d0000000", haddr_rr, hwdata_rr);
      end
      hreset = 1'b1;
   endtask

   task automatic test_fixed_priority();
      do_reset();
      busreq = 9'h014;
      step();
      tests_run++;
      if (hgrant_fp !== 9'h004) begin
         tests_failed++;
         $display("FAIL fp_grant: got %h expected %h", hgrant_fp, 9'h004);
      end
      tests_run++;
      if (hmaster_fp !== 4'd0) begin
         tests_failed++;
         $display("FAIL fp_master_before: got %0d expected 0", hmaster_fp);
      end
      step();
      tests_run++;
      if (hmaster_fp !== 4'd2 || haddr_fp !== 32'hA000_0002) begin
         tests_failed++;
         $display("FAIL fp_master_after: got %0d/%h expected 2/a0000002", hmaster_fp, haddr_fp);
      end
      step();
      tests_run++;
      if (hwdata_fp !== 32'hD000_0002) begin
         tests_failed++;
         $display("FAIL fp_wdata_owner: got %h expected d0000002", hwdata_fp);
      end
   endtask

   task automatic test_round_robin();
      logic [NM-1:0] exp_g;
      int e;
      do_reset();
      busreq = 9'h100;
      step();
      step();
      tests_run++;
      if (hmaster_rr !== 4'd8) begin
         tests_failed++;
         $display("FAIL rr_start_master: got %0d expected 8", hmaster_rr);
      end
      busreq = 9'h1FF;
      htrans = {NM{T_NONSEQ}};
      hburst = {NM{B_SINGLE}};
      for (int k = 0; k < 10; k++) begin
         e = k % NM;
         exp_g = 9'h001 << e;
         step();
         tests_run++;
         if (hgrant_rr !== exp_g) begin
            tests_failed++;
            $display("FAIL rr_grant[%0d]: got %h expected %h", k, hgrant_rr, exp_g);
         end
         step();
         tests_run++;
         if (hgrant_rr !== exp_g || hmaster_rr !== 4'(e)) begin
            tests_failed++;
            $display("FAIL rr_master[%0d]: got %h/%0d expected %h/%0d", k, hgrant_rr, hmaster_rr, exp_g, e);
         end
      end
      htrans = '0;
   endtask

   task automatic test_burst_hold();
      logic [1:0] beats [9];
      beats = '{T_SEQ, T_BUSY, T_SEQ, T_SEQ, T_BUSY, T_SEQ, T_SEQ, T_SEQ, T_SEQ};
      do_reset();
      busreq = 9'h008;
      step();
      step();
      busreq = 9'h1FF;
      drive_only(3, T_NONSEQ, B_INCR8);
      step();
      tests_run++;
      if (hgrant_rr !== 9'h008) begin
         tests_failed++;
         $display("FAIL burst_entry_grant: got %h expected %h", hgrant_rr, 9'h008);
      end
      for (int i = 0; i < 9; i++) begin
         drive_only(3, beats[i], B_INCR8);
         step();
         tests_run++;
         if (hgrant_rr !== 9'h008 || hmaster_rr !== 4'd3) begin
            tests_failed++;
            $display("FAIL burst_hold[%0d]: got %h/%0d expected 008/3", i, hgrant_rr, hmaster_rr);
         end
      end
      drive_only(3, T_IDLE, B_SINGLE);
      step();
      tests_run++;
      if (hgrant_rr !== 9'h010) begin
         tests_failed++;
         $display("FAIL burst_release: got %h expected %h", hgrant_rr, 9'h010);
      end
   endtask

   task automatic test_lock();
      do_reset();
      busreq = 9'h020;
      step();
      step();
      busreq = 9'h1FF;
      hlock  = 9'h020;
      for (int i = 0; i < 3; i++) begin
         drive_only(5, T_NONSEQ, B_SINGLE);
         step();
         tests_run++;
         if (hlock_rr !== 1'b1 || hgrant_rr !== 9'h020 || hmaster_rr !== 4'd5) begin
            tests_failed++;
            $display("FAIL lock_hold[%0d]: got %b/%h/%0d expected 1/020/5", i, hlock_rr, hgrant_rr, hmaster_rr);
         end
      end
      hlock = '0;
      drive_only(5, T_IDLE, B_SINGLE);
      step();
      tests_run++;
      if (hlock_rr !== 1'b0) begin
         tests_failed++;
         $display("FAIL lock_release: got %b expected 0", hlock_rr);
      end
      step();
      tests_run++;
      if (hgrant_rr !== 9'h040) begin
         tests_failed++;
         $display("FAIL lock_next_grant: got %h expected %h", hgrant_rr, 9'h040);
      end
   endtask

   task automatic test_hready_stall();
      do_reset();
      busreq = 9'h004;
      step();
      step();
      busreq = 9'h1FF;
      drive_only(2, T_NONSEQ, B_INCR4);
      step();
      drive_only(2, T_SEQ, B_INCR4);
      step();
      hready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (hmaster_rr !== 4'd2 || hwdata_rr !== 32'hD000_0002 || hgrant_rr !== 9'h004) begin
            tests_failed++;
            $display("FAIL stall[%0d]: got %0d/%h/%h expected 2/d0000002/004", i, hmaster_rr, hwdata_rr, hgrant_rr);
         end
      end
      hready = 1'b1;
      step();
      tests_run++;
      if (hgrant_rr !== 9'h004) begin
         tests_failed++;
         $display("FAIL stall_beat3: got %h expected %h", hgrant_rr, 9'h004);
      end
      step();
      tests_run++;
      if (hgrant_rr !== 9'h004) begin
         tests_failed++;
         $display("FAIL stall_beat4: got %h expected %h", hgrant_rr, 9'h004);
      end
      drive_only(2, T_IDLE, B_SINGLE);
      step();
      tests_run++;
      if (hgrant_rr !== 9'h008) begin
         tests_failed++;
         $display("FAIL stall_release: got %h expected %h", hgrant_rr, 9'h008);
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      busreq = 9'h002;
      step();
      step();
      busreq = 9'h1FF;
      drive_only(1, T_NONSEQ, B_WRAP16);
      step();
      for (int i = 0; i < 5; i++) begin
         drive_only(1, T_SEQ, B_WRAP16);
         step();
      end
      tests_run++;
      if (hgrant_rr !== 9'h002) begin
         tests_failed++;
         $display("FAIL wrap16_hold: got %h expected %h", hgrant_rr, 9'h002);
      end
      hreset = 1'b0;
      step();
      tests_run++;
      if (hgrant_rr !== 9'h001 || hmaster_rr !== 4'd0 || hlock_rr !== 1'b0) begin
         tests_failed++;
         $display("FAIL midburst_reset: got %h/%0d/%b expected 001/0/0", hgrant_rr, hmaster_rr, hlock_rr);
      end
      hreset = 1'b1;
      htrans = '0;
      hburst = '0;
      step();
      tests_run++;
      if (hgrant_rr !== 9'h002) begin
         tests_failed++;
         $display("FAIL midburst_reset_arb: got %h expected %h", hgrant_rr, 9'h002);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      hreset = 1'b0;
      busreq = '0;
      hlock  = '0;
      htrans = '0;
      hburst = '0;
      hready = 1'b1;
      for (int i = 0; i < NM; i++) begin
         haddr[i*AW +: AW]  = 32'hA000_0000 + 32'(i);
         hwdata[i*DW +: DW] = 32'hD000_0000 + 32'(i);
      end

      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_burst_hold();
      test_lock();
      test_hready_stall();
      test_reset_mid_burst();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
